// File: rtl/sim_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : sim_run_ctrl                                               |
// | Description : Run controller for the simulation top. Watches per-channel |
// |               halt/commit strobes, a load-once cycle budget, a no-commit |
// |               watchdog and error flags, and produces one registered      |
// |               finish/fatal verdict with a fail code.                     |
// | Option      : SIM_RUN_CTRL_HALT_ALL_EN - DRAIN only once every channel   |
// |               has halted (sticky mask); otherwise any halt bit drains.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sim_run_ctrl #(
   parameter int CHANNELS     = 8,
   parameter int TIMEOUT_W    = 64,
   parameter int STALL_W      = 32,
   parameter int DRAIN_CYCLES = 4,
   localparam int c_HALT_CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [TIMEOUT_W-1:0]   timeout_val,
   input  logic [STALL_W-1:0]     stall_limit,
   input  logic [CHANNELS-1:0]    halt,
   input  logic [CHANNELS-1:0]    commit,
   input  logic                   mon_error,
   input  logic                   mem_error,
   output logic                   finish,
   output logic                   fatal,
   output logic                   done,
   output logic [2:0]             fail_code,
   output logic [c_HALT_CH_W-1:0] halt_ch,
   output logic [TIMEOUT_W-1:0]   cycles_left
);

   localparam int             c_DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
   localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [2:0]     c_CODE_MEM   = 3'd1;
   localparam logic [2:0]     c_CODE_MON   = 3'd2;
   localparam logic [2:0]     c_CODE_TIME  = 3'd3;
   localparam logic [2:0]     c_CODE_STALL = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_PASS  = 3'd3,
      S_FAIL  = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [STALL_W-1:0]      r_stall_cnt;
   logic [STALL_W-1:0]      r_stall_lim;
   logic [c_DRAIN_W-1:0]    r_drain_cnt;
   logic [CHANNELS-1:0]     w_halt_vec;
   logic                    w_halt_hit;
   logic                    w_stall_hit;
   logic [c_HALT_CH_W-1:0]  w_halt_low;
   logic [2:0]              w_code_nxt;
   logic                    w_finish_nxt;
   logic                    w_fatal_nxt;
   logic                    w_load;
   logic                    w_dec;
   logic                    w_drain_enter;

`ifdef SIM_RUN_CTRL_HALT_ALL_EN
   logic [CHANNELS-1:0]     r_mask;

   // Sticky halt mask: cleared on a new run, accumulates halts while running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_mask <= '0;
      else if (w_load)
         r_mask <= '0;
      else if (r_state == S_RUN)
         r_mask <= r_mask | halt;
   end

   // Drain once the mask fills; candidates are the channels completing it
   always_comb begin
      w_halt_hit = &(r_mask | halt);
      w_halt_vec = halt & ~r_mask;
   end
`else
   // Any single halt bit drains; every asserted bit is a candidate
   always_comb begin
      w_halt_hit = |halt;
      w_halt_vec = halt;
   end
`endif

   // Lowest-index candidate channel (scan downward so the lowest wins)
   always_comb begin
      w_halt_low = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (w_halt_vec[i])
            w_halt_low = c_HALT_CH_W'(i);
      end
   end

   // Watchdog trips on the stall_limit-th consecutive commit-free cycle
   always_comb begin
      w_stall_hit = (r_stall_lim != '0) &&
                    (r_stall_cnt == r_stall_lim - STALL_W'(1)) &&
                    (commit == '0);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and verdict decode; errors outrank budget, watchdog, then halt
   always_comb begin
      w_state_nxt   = r_state;
      w_code_nxt    = fail_code;
      w_finish_nxt  = 1'b0;
      w_fatal_nxt   = 1'b0;
      w_load        = 1'b0;
      w_dec         = 1'b0;
      w_drain_enter = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_load      = 1'b1;
            end
         end
         S_RUN: begin
            if (mem_error) begin
               w_state_nxt = S_FAIL;
               w_code_nxt  = c_CODE_MEM;
               w_fatal_nxt = 1'b1;
            end else if (mon_error) begin
               w_state_nxt = S_FAIL;
               w_code_nxt  = c_CODE_MON;
               w_fatal_nxt = 1'b1;
            end else if (cycles_left == '0) begin
               w_state_nxt = S_FAIL;
               w_code_nxt  = c_CODE_TIME;
               w_fatal_nxt = 1'b1;
            end else if (w_stall_hit) begin
               w_state_nxt = S_FAIL;
               w_code_nxt  = c_CODE_STALL;
               w_fatal_nxt = 1'b1;
            end else begin
               w_dec = 1'b1;
               if (w_halt_hit) begin
                  w_state_nxt   = S_DRAIN;
                  w_drain_enter = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (mem_error) begin
               w_state_nxt = S_FAIL;
               w_code_nxt  = c_CODE_MEM;
               w_fatal_nxt = 1'b1;
            end else if (mon_error) begin
               w_state_nxt = S_FAIL;
               w_code_nxt  = c_CODE_MON;
               w_fatal_nxt = 1'b1;
            end else begin
               w_dec = (cycles_left != '0);
               if (r_drain_cnt == c_DRAIN_LAST) begin
                  w_state_nxt  = S_PASS;
                  w_finish_nxt = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Registered verdict outputs and remaining budget
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         finish      <= 1'b0;
         fatal       <= 1'b0;
         done        <= 1'b0;
         fail_code   <= 3'd0;
         halt_ch     <= '0;
         cycles_left <= '0;
      end else begin
         finish    <= w_finish_nxt;
         fatal     <= w_fatal_nxt;
         done      <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
         fail_code <= w_code_nxt;
         if (w_drain_enter)
            halt_ch <= w_halt_low;
         if (w_load)
            cycles_left <= timeout_val;
         else if (w_dec)
            cycles_left <= cycles_left - TIMEOUT_W'(1);
      end
   end

   // Watchdog counter, latched stall limit and drain counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_stall_lim <= '0;
         r_drain_cnt <= '0;
      end else begin
         if (w_load) begin
            r_stall_cnt <= '0;
            r_stall_lim <= stall_limit;
         end else if (r_state == S_RUN) begin
            if (|commit)
               r_stall_cnt <= '0;
            else if (r_stall_cnt != '1)
               r_stall_cnt <= r_stall_cnt + STALL_W'(1);
         end
         if (w_drain_enter)
            r_drain_cnt <= '0;
         else if (r_state == S_DRAIN)
            r_drain_cnt <= r_drain_cnt + c_DRAIN_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_sim_run_ctrl                                            |
// | Description : Scoreboard bench for sim_run_ctrl. Each run's verdict is   |
// |               predicted from event times (first error, budget expiry,    |
// |               watchdog window, first halt) and popped by a monitor.      |
// | Option      : SIM_RUN_CTRL_HALT_ALL_EN selects the 4-channel all-halt    |
// |               build and the matching prediction rule.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sim_run_ctrl;

`ifdef SIM_RUN_CTRL_HALT_ALL_EN
   localparam int c_CH = 4;
`else
   localparam int c_CH = 8;
`endif
   localparam int c_HW    = $clog2(c_CH);
   localparam int c_DRAIN = 4;
   localparam int c_MAXC  = 320;
   localparam int c_INF   = 1000000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [63:0]     timeout_val;
   logic [31:0]     stall_limit;
   logic [c_CH-1:0] halt;
   logic [c_CH-1:0] commit;
   logic            mon_error;
   logic            mem_error;
   logic            finish;
   logic            fatal;
   logic            done;
   logic [2:0]      fail_code;
   logic [c_HW-1:0] halt_ch;
   logic [63:0]     cycles_left;

   sim_run_ctrl #(
      .CHANNELS     (c_CH),
      .TIMEOUT_W    (64),
      .STALL_W      (32),
      .DRAIN_CYCLES (c_DRAIN)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .timeout_val (timeout_val),
      .stall_limit (stall_limit),
      .halt        (halt),
      .commit      (commit),
      .mon_error   (mon_error),
      .mem_error   (mem_error),
      .finish      (finish),
      .fatal       (fatal),
      .done        (done),
      .fail_code   (fail_code),
      .halt_ch     (halt_ch),
      .cycles_left (cycles_left)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit     pass;
      int     code;
      int     hch;
      longint cl;
      int     cyc;
   } exp_t;

   exp_t sb[$];
   int   total;
   int   bad;

   // Scenario: per-cycle stimulus indexed by RUN cycle number (1-based)
   logic [c_CH-1:0] s_halt   [c_MAXC+1];
   logic [c_CH-1:0] s_commit [c_MAXC+1];
   bit              s_mem    [c_MAXC+1];
   bit              s_mon    [c_MAXC+1];
   bit              s_startn [c_MAXC+1];
   longint          s_to;
   int              s_sl;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int lowest(input logic [c_CH-1:0] v);
      for (int i = 0; i < c_CH; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   task automatic clear_scen();
      for (int k = 0; k <= c_MAXC; k++) begin
         s_halt[k] = '0; s_commit[k] = '0;
         s_mem[k] = 1'b0; s_mon[k] = 1'b0; s_startn[k] = 1'b0;
      end
      s_to = 0;
      s_sl = 0;
   endtask

   // Predict the verdict from the first occurrence of each terminating event
   task automatic push_expected();
      exp_t e;
      int t_mem = c_INF, t_mon = c_INF, t_st = c_INF, t_h = c_INF;
      int t_to, t_end, run_len = 0, hch = 0;
      logic [c_CH-1:0] acc = '0;
      t_to = int'(s_to) + 1;
      for (int k = 1; k <= c_MAXC; k++) begin
         if (s_mem[k] && t_mem == c_INF) t_mem = k;
         if (s_mon[k] && t_mon == c_INF) t_mon = k;
         if (s_commit[k] == '0) run_len++; else run_len = 0;
         if (s_sl != 0 && run_len >= s_sl && t_st == c_INF) t_st = k;
`ifdef SIM_RUN_CTRL_HALT_ALL_EN
         if (t_h == c_INF && (acc | s_halt[k]) == '1) begin
            t_h = k;
            hch = lowest(s_halt[k] & ~acc);
         end
         acc = acc | s_halt[k];
`else
         if (t_h == c_INF && s_halt[k] != '0) begin
            t_h = k;
            hch = lowest(s_halt[k]);
         end
`endif
      end
      t_end = t_to;
      if (t_mem < t_end) t_end = t_mem;
      if (t_mon < t_end) t_end = t_mon;
      if (t_st  < t_end) t_end = t_st;
      if (t_h   < t_end) t_end = t_h;
      e.pass = 1'b0; e.hch = 0; e.cyc = t_end;
      e.cl = s_to - longint'(t_end - 1);
      if (t_mem == t_end)      e.code = 1;
      else if (t_mon == t_end) e.code = 2;
      else if (t_to == t_end)  e.code = 3;
      else if (t_st == t_end)  e.code = 4;
      else begin
         e.hch = hch; e.pass = 1'b1; e.code = 0; e.cyc = t_h + c_DRAIN;
         for (int k = t_h + 1; k <= t_h + c_DRAIN; k++) begin
            if (s_mem[k] || s_mon[k]) begin
               e.pass = 1'b0;
               e.code = s_mem[k] ? 1 : 2;
               e.cyc  = k;
               break;
            end
         end
         e.cl = s_to - longint'(e.pass ? e.cyc : e.cyc - 1);
         if (e.cl < 0) e.cl = 0;
      end
      sb.push_back(e);
   endtask

   task automatic gen_random();
      int pcom, ph, perr;
      logic [c_CH-1:0] v;
      clear_scen();
      s_to = longint'($urandom_range(0, 250));
      s_sl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
      pcom = int'($urandom_range(40, 100));
      ph   = int'($urandom_range(0, 10));
      perr = ($urandom_range(0, 2) == 0) ? 2 : 0;
      for (int k = 1; k <= c_MAXC; k++) begin
         v = c_CH'($urandom);
         if (v == '0) v[0] = 1'b1;
         if (int'($urandom_range(1, 100)) <= pcom) s_commit[k] = v;
         if (int'($urandom_range(1, 100)) <= ph) begin
            if ($urandom_range(0, 1) == 0) begin
               s_halt[k] = '0;
               s_halt[k][$urandom_range(0, c_CH - 1)] = 1'b1;
            end else begin
               s_halt[k] = c_CH'($urandom);
            end
         end
         s_mem[k]    = (int'($urandom_range(1, 200)) <= perr);
         s_mon[k]    = (int'($urandom_range(1, 200)) <= perr);
         s_startn[k] = ($urandom_range(1, 20) == 1);
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; halt = '0; commit = '0; mem_error = 1'b0; mon_error = 1'b0;
   endtask

   // Reset, issue start, then play the scenario until a verdict or abort
   task automatic run_scen(input int abort_at);
      bit got = 1'b0;
      bit aborted = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      push_expected();
      idle_inputs();
      start = 1'b1;
      timeout_val = 64'(s_to);
      stall_limit = 32'(s_sl);
      @(negedge clk);
      for (int k = 1; k <= c_MAXC; k++) begin
         start = s_startn[k]; halt = s_halt[k]; commit = s_commit[k];
         mem_error = s_mem[k]; mon_error = s_mon[k];
         if (k == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_done",        longint'(done), 0);
            check("rst_finish",      longint'(finish), 0);
            check("rst_fatal",       longint'(fatal), 0);
            check("rst_fail_code",   longint'(fail_code), 0);
            check("rst_halt_ch",     longint'(halt_ch), 0);
            check("rst_cycles_left", longint'(cycles_left), 0);
            if (sb.size() > 0) sb.pop_back();
            aborted = 1'b1;
            @(negedge clk); rst_n = 1'b1;
            break;
         end
         @(posedge clk); #2;
         if (done) begin got = 1'b1; break; end
         @(negedge clk);
      end
      idle_inputs();
      if (!aborted) begin
         check("verdict_seen", longint'(got), 1);
         if (!got && sb.size() > 0) sb.pop_back();
         if (got) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            @(posedge clk); #2;
            check("done_held", longint'(done), 1);
         end
      end
   endtask

   // Monitor: pops one expected verdict per finish/fatal pulse
   initial begin : monitor
      bit running = 1'b0;
      bit prev_pulse = 1'b0;
      int cyc = 0;
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            running = 1'b0;
            prev_pulse = 1'b0;
         end else begin
            if (prev_pulse) begin
               check("pulse_width", longint'(finish | fatal), 0);
               check("done_level",  longint'(done), 1);
            end
            prev_pulse = 1'b0;
            if (running) cyc++;
            if (start && !running && !done) begin
               running = 1'b1;
               cyc = 0;
            end
            if (finish || fatal) begin
               check("single_verdict", longint'(finish & fatal), 0);
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_verdict actual=finish%0d/fatal%0d required=none", finish, fatal);
               end else begin
                  e = sb.pop_front();
                  check("verdict_pass",  longint'(finish), longint'(e.pass));
                  check("verdict_fatal", longint'(fatal), longint'(!e.pass));
                  check("fail_code",     longint'(fail_code), longint'(e.code));
                  check("halt_ch",       longint'(halt_ch), longint'(e.hch));
                  check("cycles_left",   longint'(cycles_left), e.cl);
                  check("verdict_cycle", longint'(cyc), longint'(e.cyc));
                  check("done_on_pulse", longint'(done), 1);
               end
               running = 1'b0;
               prev_pulse = 1'b1;
            end
         end
      end
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin : stimulus
      total = 0; bad = 0;
      rst_n = 1'b0; timeout_val = '0; stall_limit = '0;
      idle_inputs();
      #3;
      check("reset_done",        longint'(done), 0);
      check("reset_finish",      longint'(finish), 0);
      check("reset_fatal",       longint'(fatal), 0);
      check("reset_fail_code",   longint'(fail_code), 0);
      check("reset_halt_ch",     longint'(halt_ch), 0);
      check("reset_cycles_left", longint'(cycles_left), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Halt on channel 3 at cycle 10 with a 100-cycle budget
      clear_scen(); s_to = 100;
      for (int k = 1; k <= c_MAXC; k++) s_commit[k] = '1;
      s_halt[10][3] = 1'b1;
      run_scen(0);

      // Budget of 5 runs out
      clear_scen(); s_to = 5;
      for (int k = 1; k <= c_MAXC; k++) s_commit[k] = '1;
      run_scen(0);

      // Budget of 0 fails on the first RUN cycle
      clear_scen(); s_to = 0;
      run_scen(0);

      // Watchdog of 8 after commits stop at cycle 2, then watchdog disabled
      clear_scen(); s_to = 200; s_sl = 8;
      s_commit[1] = '1; s_commit[2] = '1;
      run_scen(0);
      clear_scen(); s_to = 40; s_sl = 0;
      s_commit[1] = '1; s_commit[2] = '1;
      run_scen(0);

      // Both errors plus a halt in one cycle, then a monitor error while draining
      clear_scen(); s_to = 100;
      for (int k = 1; k <= c_MAXC; k++) s_commit[k] = '1;
      s_mem[6] = 1'b1; s_mon[6] = 1'b1; s_halt[6][0] = 1'b1;
      run_scen(0);
      clear_scen(); s_to = 100;
      for (int k = 1; k <= c_MAXC; k++) s_commit[k] = '1;
      s_halt[6] = '1; s_mon[8] = 1'b1;
      run_scen(0);

      // Reset asserted mid-drain, then a clean run
      clear_scen(); s_to = 100;
      for (int k = 1; k <= c_MAXC; k++) s_commit[k] = '1;
      s_halt[10][3] = 1'b1;
      run_scen(12);
      run_scen(0);

      // Halts arriving piecemeal on channels 0,2 then 1 then 3
      clear_scen(); s_to = 100;
      for (int k = 1; k <= c_MAXC; k++) s_commit[k] = '1;
      s_halt[3][0] = 1'b1; s_halt[3][2] = 1'b1;
      s_halt[5][1] = 1'b1;
      s_halt[8][3] = 1'b1;
      run_scen(0);

      // Randomised runs, occasionally cut short by reset
      repeat (60) begin
         gen_random();
         run_scen(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", longint'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
